// File: rtl/food_placer.sv
// food_placer: proposes random interior cells from two button-seeded LFSRs,
// verifies them against the block map, and falls back to a raster scan.
module food_placer #(
   parameter int GRID_HEIGHT = 24,
   parameter int GRID_WIDTH = 32,
   parameter int BITS_PER_BLOCK = 2,
   parameter logic [BITS_PER_BLOCK-1:0] BLOCK_EMPTY = '0,
   parameter int MAX_TRIES = 8,
   parameter logic [15:0] SEED_V = 16'hACE1,
   parameter logic [15:0] SEED_H = 16'h1D0F,
   localparam int VW = $clog2(GRID_HEIGHT),
   localparam int HW = $clog2(GRID_WIDTH)
) (
   input  logic                      MasterClock,
   input  logic                      ResetN,
   input  logic                      ButtonLeft,
   input  logic                      ButtonRight,
   input  logic                      ButtonUp,
   input  logic                      ButtonDown,
   input  logic                      ButtonCenter,
   input  logic                      Request,
   output logic                      ReadEn,
   output logic [VW-1:0]             ReadV,
   output logic [HW-1:0]             ReadH,
   input  logic [BITS_PER_BLOCK-1:0] ReadBlock,
   output logic                      Busy,
   output logic                      FoodValid,
   output logic                      GridFull,
   output logic [VW-1:0]             NextFoodV,
   output logic [HW-1:0]             NextFoodH
);
   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam int CELLS = (GRID_HEIGHT - 2) * (GRID_WIDTH - 2);
   localparam int CW = $clog2(CELLS + 1);
   localparam logic [VW-1:0] V_ONE = VW'(1);
   localparam logic [VW-1:0] V_MAX = VW'(GRID_HEIGHT - 2);
   localparam logic [HW-1:0] H_ONE = HW'(1);
   localparam logic [HW-1:0] H_MAX = HW'(GRID_WIDTH - 2);
   localparam logic [TW-1:0] T_MAX = TW'(MAX_TRIES);
   localparam logic [CW-1:0] C_MAX = CW'(CELLS);

   typedef enum logic [2:0] {IDLE, PROPOSE, CHECK, SCAN_INIT, SCAN_RD, SCAN_CK, DONE, FULL} state_t;
   state_t state_q, state_d;
   logic [15:0] lfsr_v_q, lfsr_v_d, lfsr_h_q, lfsr_h_d, step_v, step_h;
   logic [TW-1:0] tries_q, tries_d;
   logic [CW-1:0] scan_cnt_q, scan_cnt_d;
   logic [VW-1:0] cand_v, last_v_q, last_v_d, scan_v_q, scan_v_d, food_v_q, food_v_d;
   logic [HW-1:0] cand_h, last_h_q, last_h_d, scan_h_q, scan_h_d, food_h_q, food_h_d;
   logic last_ok_q, last_ok_d, in_range, empty;

   always_comb begin
      step_v = {lfsr_v_q[14:0], lfsr_v_q[15] ^ lfsr_v_q[13] ^ lfsr_v_q[12] ^ lfsr_v_q[10]
                ^ ButtonLeft ^ ButtonDown ^ ButtonCenter};
      step_h = {lfsr_h_q[14:0], lfsr_h_q[15] ^ lfsr_h_q[13] ^ lfsr_h_q[12] ^ lfsr_h_q[10]
                ^ ButtonRight ^ ButtonUp ^ ButtonCenter};
      lfsr_v_d = (step_v == '0) ? SEED_V : step_v;
      lfsr_h_d = (step_h == '0) ? SEED_H : step_h;
      cand_v = lfsr_v_q[VW-1:0];
      cand_h = lfsr_h_q[HW-1:0];
      in_range = cand_v >= V_ONE && cand_v <= V_MAX && cand_h >= H_ONE && cand_h <= H_MAX;
      empty = ReadBlock == BLOCK_EMPTY;
      Busy = state_q != IDLE;
      FoodValid = state_q == DONE;
      GridFull = state_q == FULL;
      NextFoodV = food_v_q;
      NextFoodH = food_h_q;
   end

   always_comb begin
      state_d = state_q;
      tries_d = tries_q;
      scan_cnt_d = scan_cnt_q;
      last_v_d = last_v_q;
      last_h_d = last_h_q;
      last_ok_d = last_ok_q;
      scan_v_d = scan_v_q;
      scan_h_d = scan_h_q;
      food_v_d = food_v_q;
      food_h_d = food_h_q;
      ReadEn = 1'b0;
      ReadV = '0;
      ReadH = '0;
      case (state_q)
         IDLE: if (Request) begin
            tries_d = '0;
            last_ok_d = 1'b0;
            state_d = PROPOSE;
         end
         PROPOSE: begin
            tries_d = tries_q + 1'b1;
            if (in_range) begin
               ReadEn = 1'b1;
               ReadV = cand_v;
               ReadH = cand_h;
               last_v_d = cand_v;
               last_h_d = cand_h;
               last_ok_d = 1'b1;
               state_d = CHECK;
            end else state_d = (tries_d < T_MAX) ? PROPOSE : SCAN_INIT;
         end
         CHECK: if (empty) begin
            food_v_d = last_v_q;
            food_h_d = last_h_q;
            state_d = DONE;
         end else state_d = (tries_q < T_MAX) ? PROPOSE : SCAN_INIT;
         SCAN_INIT: begin
            scan_v_d = last_ok_q ? last_v_q : V_ONE;
            scan_h_d = last_ok_q ? last_h_q : H_ONE;
            scan_cnt_d = '0;
            state_d = SCAN_RD;
         end
         SCAN_RD: begin
            ReadEn = 1'b1;
            ReadV = scan_v_q;
            ReadH = scan_h_q;
            state_d = SCAN_CK;
         end
         SCAN_CK: if (empty) begin
            food_v_d = scan_v_q;
            food_h_d = scan_h_q;
            state_d = DONE;
         end else begin
            // raster advance over the interior only, wrapping back to (1,1)
            scan_cnt_d = scan_cnt_q + 1'b1;
            scan_h_d = (scan_h_q == H_MAX) ? H_ONE : scan_h_q + 1'b1;
            scan_v_d = (scan_h_q != H_MAX) ? scan_v_q : (scan_v_q == V_MAX) ? V_ONE : scan_v_q + 1'b1;
            state_d = (scan_cnt_d == C_MAX) ? FULL : SCAN_RD;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge MasterClock) begin
      if (!ResetN) begin
         state_q <= IDLE;
         lfsr_v_q <= SEED_V;
         lfsr_h_q <= SEED_H;
         tries_q <= '0;
         scan_cnt_q <= '0;
         last_v_q <= '0;
         last_h_q <= '0;
         last_ok_q <= 1'b0;
         scan_v_q <= '0;
         scan_h_q <= '0;
         food_v_q <= '0;
         food_h_q <= '0;
      end else begin
         state_q <= state_d;
         lfsr_v_q <= lfsr_v_d;
         lfsr_h_q <= lfsr_h_d;
         tries_q <= tries_d;
         scan_cnt_q <= scan_cnt_d;
         last_v_q <= last_v_d;
         last_h_q <= last_h_d;
         last_ok_q <= last_ok_d;
         scan_v_q <= scan_v_d;
         scan_h_q <= scan_h_d;
         food_v_q <= food_v_d;
         food_h_q <= food_h_d;
      end
   end
endmodule

// File: tb/tb_food_placer.sv
// tb_food_placer: directed checks on a 24x32, a 5x5 (one try) and a 4x4 placer
// sharing clock, reset and buttons.
module tb_food_placer;
   logic clk = 1'b0;
   logic rst_n, bl, br, bu, bd, bc, tog;
   logic req_b, en_b, busy_b, fv_b, gf_b;
   logic [4:0] rdv_b, rdh_b, nfv_b, nfh_b;
   logic [1:0] rb_b;
   logic req_s, en_s, busy_s, fv_s, gf_s, mode_s;
   logic [2:0] rdv_s, rdh_s, nfv_s, nfh_s;
   logic [1:0] rb_s;
   logic req_t, en_t, busy_t, fv_t, gf_t, mode_t;
   logic [1:0] rdv_t, rdh_t, nfv_t, nfh_t;
   logic [1:0] rb_t;
   logic [15:0] mv, mh;
   logic [4:0] r1v, r1h, ev, eh;
   logic started = 1'b0;
   int checks = 0, errors = 0, bad_rd = 0, bad_idle = 0, zero_cnt = 0;

   always #5 clk = ~clk;

   food_placer u_big (
      .MasterClock(clk), .ResetN(rst_n), .ButtonLeft(bl), .ButtonRight(br), .ButtonUp(bu),
      .ButtonDown(bd), .ButtonCenter(bc), .Request(req_b), .ReadEn(en_b), .ReadV(rdv_b),
      .ReadH(rdh_b), .ReadBlock(rb_b), .Busy(busy_b), .FoodValid(fv_b), .GridFull(gf_b),
      .NextFoodV(nfv_b), .NextFoodH(nfh_b));

   food_placer #(.GRID_HEIGHT(5), .GRID_WIDTH(5), .MAX_TRIES(1)) u_small (
      .MasterClock(clk), .ResetN(rst_n), .ButtonLeft(bl), .ButtonRight(br), .ButtonUp(bu),
      .ButtonDown(bd), .ButtonCenter(bc), .Request(req_s), .ReadEn(en_s), .ReadV(rdv_s),
      .ReadH(rdh_s), .ReadBlock(rb_s), .Busy(busy_s), .FoodValid(fv_s), .GridFull(gf_s),
      .NextFoodV(nfv_s), .NextFoodH(nfh_s));

   food_placer #(.GRID_HEIGHT(4), .GRID_WIDTH(4)) u_tiny (
      .MasterClock(clk), .ResetN(rst_n), .ButtonLeft(bl), .ButtonRight(br), .ButtonUp(bu),
      .ButtonDown(bd), .ButtonCenter(bc), .Request(req_t), .ReadEn(en_t), .ReadV(rdv_t),
      .ReadH(rdh_t), .ReadBlock(rb_t), .Busy(busy_t), .FoodValid(fv_t), .GridFull(gf_t),
      .NextFoodV(nfv_t), .NextFoodH(nfh_t));

   // block maps: big is all empty; small/tiny have one empty cell (mode 0) or none (mode 1)
   assign rb_b = 2'd0;
   always @(posedge clk) begin
      rb_s <= (en_s && !mode_s && rdv_s == 3'd3 && rdh_s == 3'd3) ? 2'd0 : 2'd1;
      rb_t <= (en_t && !mode_t && rdv_t == 2'd2 && rdh_t == 2'd2) ? 2'd0 : 2'd2;
   end

   function automatic logic [15:0] lstep(input logic [15:0] s, input logic b, input logic [15:0] seed);
      logic [15:0] n;
      n = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ b};
      return (n == 16'd0) ? seed : n;
   endfunction

   always @(posedge clk) begin
      mv <= !rst_n ? 16'hACE1 : lstep(mv, bl ^ bd ^ bc, 16'hACE1);
      mh <= !rst_n ? 16'h1D0F : lstep(mh, br ^ bu ^ bc, 16'h1D0F);
   end

   always @(negedge clk) if (started) begin
      if ((en_s && (rdv_s == 3'd0 || rdv_s > 3'd3 || rdh_s == 3'd0 || rdh_s > 3'd3)) ||
          (en_t && (rdv_t == 2'd0 || rdv_t == 2'd3 || rdh_t == 2'd0 || rdh_t == 2'd3)) ||
          (en_b && (rdv_b == 5'd0 || rdv_b > 5'd22 || rdh_b == 5'd0 || rdh_b > 5'd30)))
         bad_rd++;
      if ((!en_b && (rdv_b | rdh_b) != 5'd0) || (!en_s && (rdv_s | rdh_s) != 3'd0) ||
          (!en_t && (rdv_t | rdh_t) != 2'd0))
         bad_idle++;
      if (rst_n && (u_big.lfsr_v_q == 16'd0 || u_big.lfsr_h_q == 16'd0)) zero_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      if (tog) bc = ~bc;
   endtask

   // one request on the big grid; expected cell predicted from the LFSR model
   task automatic run_big(input string tag, output logic [4:0] pv, output logic [4:0] ph);
      int pd;
      bit found, done;
      req_b = 1'b1;
      tick;
      req_b = 1'b0;
      found = 0;
      done = 0;
      pd = -1;
      pv = '0;
      ph = '0;
      for (int c = 0; c < 2 * 8 + 4 && !done; c++) begin
         if (!found && c < 8 && mv[4:0] >= 5'd1 && mv[4:0] <= 5'd22 && mh[4:0] >= 5'd1 && mh[4:0] <= 5'd30) begin
            found = 1;
            pd = c;
            pv = mv[4:0];
            ph = mh[4:0];
            chk({tag, "_rden"}, en_b, 1);
            chk({tag, "_rdv"}, rdv_b, pv);
            chk({tag, "_rdh"}, rdh_b, ph);
         end
         if (!found && c == 8) begin
            found = 1;
            pd = 9;
            pv = 5'd1;
            ph = 5'd1;
         end
         if (fv_b) begin
            done = 1;
            chk({tag, "_lat"}, c, pd + 2);
            chk({tag, "_v"}, nfv_b, pv);
            chk({tag, "_h"}, nfh_b, ph);
            chk({tag, "_busy"}, busy_b, 1);
         end else tick;
      end
      if (!done) chk({tag, "_timeout"}, 0, 1);
      tick;
      chk({tag, "_idle"}, busy_b, 0);
   endtask

   initial begin
      int fvc, gfc, gfat, results, after_fv;
      bit seen;
      rst_n = 1'b0;
      {bl, br, bu, bd, bc} = '0;
      tog = 1'b0;
      req_b = 1'b0;
      req_s = 1'b0;
      req_t = 1'b0;
      mode_s = 1'b0;
      mode_t = 1'b0;
      tick;
      tick;
      started = 1'b1;
      chk("rst_busy_b", busy_b, 0);
      chk("rst_fv_b", fv_b, 0);
      chk("rst_gf_b", gf_b, 0);
      chk("rst_en_b", en_b, 0);
      chk("rst_nfv_b", nfv_b, 0);
      chk("rst_nfh_b", nfh_b, 0);
      chk("rst_busy_s", busy_s, 0);
      chk("rst_busy_t", busy_t, 0);
      rst_n = 1'b1;
      run_big("run1", ev, eh);
      r1v = ev;
      r1h = eh;
      chk("run1_hand_v", nfv_b, 3);
      chk("run1_hand_h", nfh_b, 30);

      mode_s = 1'b0;
      req_s = 1'b1;
      tick;
      req_s = 1'b0;
      for (int c = 0; c < 40 && !fv_s; c++) tick;
      chk("s_find_fv", fv_s, 1);
      chk("s_find_v", nfv_s, 3);
      chk("s_find_h", nfh_s, 3);
      tick;

      mode_s = 1'b1;
      req_s = 1'b1;
      tick;
      req_s = 1'b0;
      seen = 0;
      for (int c = 0; c < 12 && !seen; c++) begin
         if (c >= 3 && en_s) seen = 1;
         else tick;
      end
      chk("s_scanrd_seen", seen, 1);
      rst_n = 1'b0;
      tick;
      chk("mid_rst_busy", busy_s, 0);
      chk("mid_rst_en", en_s, 0);
      chk("mid_rst_rd", {rdv_s, rdh_s}, 0);
      chk("mid_rst_fv_gf", {fv_s, gf_s}, 0);
      chk("mid_rst_nf", {nfv_s, nfh_s}, 0);
      rst_n = 1'b1;
      run_big("run2", ev, eh);
      chk("determ_v", nfv_b, r1v);
      chk("determ_h", nfh_b, r1h);

      mode_s = 1'b0;
      req_s = 1'b1;
      tick;
      req_s = 1'b0;
      for (int c = 0; c < 40 && !fv_s; c++) tick;
      chk("s_restart_fv", fv_s, 1);
      chk("s_restart_vh", {nfv_s, nfh_s}, {3'd3, 3'd3});
      tick;

      mode_t = 1'b0;
      req_t = 1'b1;
      tick;
      req_t = 1'b0;
      for (int c = 0; c < 40 && !fv_t; c++) tick;
      chk("t_find_fv", fv_t, 1);
      chk("t_find_vh", {nfv_t, nfh_t}, {2'd2, 2'd2});
      tick;
      mode_t = 1'b1;
      req_t = 1'b1;
      tick;
      req_t = 1'b0;
      fvc = 0;
      gfc = 0;
      gfat = -1;
      for (int c = 0; c < 40; c++) begin
         if (gf_t) begin
            gfc++;
            gfat = c;
         end
         if (fv_t) fvc++;
         tick;
      end
      chk("t_full_pulses", gfc, 1);
      chk("t_full_no_fv", fvc, 0);
      chk("t_full_in_bound", gfat >= 0 && gfat <= 26, 1);
      chk("t_full_keep_vh", {nfv_t, nfh_t}, {2'd2, 2'd2});

      req_b = 1'b1;
      results = 0;
      after_fv = 0;
      for (int c = 0; c < 80; c++) begin
         tick;
         if (after_fv == 1) chk("hold_gap_idle", busy_b, 0);
         if (after_fv == 2) chk("hold_gap_restart", busy_b, 1);
         after_fv = fv_b ? 1 : (after_fv == 1 ? 2 : 0);
         results += int'(fv_b);
      end
      req_b = 1'b0;
      chk("hold_results", results >= 3, 1);

      rst_n = 1'b0;
      tog = 1'b1;
      tick;
      rst_n = 1'b1;
      run_big("tog", ev, eh);
      chk("tog_hand_v", nfv_b, 5);
      chk("tog_hand_h", nfh_b, 30);
      tog = 1'b0;
      bc = 1'b0;
      tick;

      chk("border_reads", bad_rd, 0);
      chk("idle_addr_zero", bad_idle, 0);
      chk("lfsr_nonzero", zero_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/food_placer.md
# food_placer

Parametrised food-position generator for the snake game. On request it proposes random interior grid cells from two free-running, button-seeded 16-bit LFSRs. Each candidate is checked against the block map through a one-cycle-latency read port. After MAX_TRIES random rejections it falls back to a deterministic raster scan, and it reports grid-full when no empty interior cell exists. It sits between the game-logic FSM, which requests new food, and the block-map RAM.

## Interface

- GRID_HEIGHT, 24: rows; must be ≥3. VW = $clog2(GRID_HEIGHT).
- GRID_WIDTH, 32: columns; must be ≥3. HW = $clog2(GRID_WIDTH).
- BITS_PER_BLOCK, 2: block-type width.
- BLOCK_EMPTY, 0: encoding of an empty cell.
- MAX_TRIES, 8: random attempts before scan fallback; must be ≥1.
- SEED_V, 16'hACE1: reset and anti-lockup value of the row LFSR.
- SEED_H, 16'h1D0F: reset and anti-lockup value of the column LFSR.

- MasterClock  in  1  sole clock; all logic on posedge.
- ResetN  in  1  synchronous, active-low reset.
- ButtonLeft, ButtonRight, ButtonUp, ButtonDown, ButtonCenter  in  1 each  entropy inputs, level-sampled each cycle.
- Request  in  1  new-food request, sampled only in IDLE.
- ReadEn  out  1  block-map read strobe.
- ReadV  out  VW  block-map read row.
- ReadH  out  HW  block-map read column.
- ReadBlock  in  BITS_PER_BLOCK  block-map data, valid the cycle after ReadEn.
- Busy  out  1  high from request accept until the cycle FoodValid or GridFull pulses, inclusive.
- FoodValid  out  1  one-cycle pulse: NextFoodV/H hold a new empty cell.
- GridFull  out  1  one-cycle pulse: no empty interior cell was found.
- NextFoodV  out  VW  result row; holds until the next FoodValid.
- NextFoodH  out  HW  result column; holds until the next FoodValid.

## Operation

- LFSRs step every cycle in every state.
  - Row LFSR: Fibonacci, taps 16,14,13,11. Feedback XORed with ButtonLeft^ButtonDown^ButtonCenter.
  - Column LFSR: same taps. Feedback XORed with ButtonRight^ButtonUp^ButtonCenter.
  - If a computed next value is all-zero, load the seed instead.
- Candidate: V = LfsrV[VW-1:0], H = LfsrH[HW-1:0], both captured in PROPOSE.
  - In range iff 1 ≤ V ≤ GRID_HEIGHT-2 and 1 ≤ H ≤ GRID_WIDTH-2.
- States:
  - IDLE: Busy=0. If Request=1, clear Tries and the LastInRange flag, then go to PROPOSE.
  - PROPOSE: capture candidate and increment Tries.
    - In range: drive ReadEn/ReadV/ReadH, record candidate as LastCand, set LastInRange, go to CHECK.
    - Out of range: no read. Go to PROPOSE if Tries<MAX_TRIES, else SCAN_INIT.
  - CHECK: if ReadBlock==BLOCK_EMPTY, load NextFoodV/H and go to DONE. Else PROPOSE if Tries<MAX_TRIES, else SCAN_INIT.
  - SCAN_INIT: Scan = LastCand if LastInRange, else (1,1). Clear ScanCount. Go to SCAN_RD.
  - SCAN_RD: read at Scan, go to SCAN_CK.
  - SCAN_CK:
    - Empty: load result, go to DONE.
    - Else: ScanCount++ and advance Scan in raster order (H+1; at H=GRID_WIDTH-2 wrap to H=1 and V+1; at V=GRID_HEIGHT-2 wrap to V=1).
    - If ScanCount reaches (GRID_HEIGHT-2)*(GRID_WIDTH-2), go to FULL, else SCAN_RD.
  - DONE: FoodValid=1 for one cycle, go to IDLE.
  - FULL: GridFull=1 for one cycle, NextFoodV/H unchanged, go to IDLE.
- Border cells are never read and never returned.
- Request while Busy is ignored; it is not queued.
- ReadEn is high only in PROPOSE (in-range candidate) and SCAN_RD.
- ReadV/H are 0 whenever ReadEn=0.

## Timing

- Reset (ResetN=0 at a posedge):
  - state → IDLE; LFSRs → seeds.
  - NextFoodV/H, FoodValid, GridFull, Busy, ReadEn, ReadV, ReadH all → 0.
  - Takes priority over every state, including mid-search; the in-progress request is dropped.
- Request sampled at edge t.
- Best case: PROPOSE at t+1, CHECK at t+2, DONE at t+3.
- Each rejected in-range try adds 2 cycles; each out-of-range try adds 1.
- Each scanned cell costs 2 cycles.
- Worst case (full grid): ≤ 2·MAX_TRIES + 1 + 2·(GRID_HEIGHT-2)(GRID_WIDTH-2) + 1 cycles after accept.
- Block-map may change during a search. Only the sampled ReadBlock decides; no re-validation.

## Test plan

- Reset mid-search: assert ResetN=0 while in SCAN_RD → next cycle all outputs 0, Busy=0. A Request after release restarts, and LFSRs restart from the seeds (ACE1/1D0F).
- Empty 24x32 map, buttons idle, Request at cycle 0 → FoodValid within ≤2·MAX_TRIES+4 cycles with 1≤V≤22, 1≤H≤30. Result identical across two runs from reset (determinism).
- 5x5 map, MAX_TRIES=1, forced non-empty reads except cell (3,3) → scan finds it: FoodValid, NextFoodV=3, NextFoodH=3. No read ever hits row/col 0 or 4.
- 4x4 map, all interior non-empty → GridFull pulses exactly once after 4 scan checks. FoodValid stays 0 and NextFoodV/H keep their previous values.
- Request held high continuously → one result per search, Busy low for exactly one IDLE cycle between searches, and no Request is accepted while Busy=1.
- Toggle ButtonCenter each cycle from reset → candidate sequence differs from the idle-button run, and the LFSRs never hold 0 (assertion).
